// File: rtl/riscvibe_pkg.sv
// ============================================================================
// Module      : riscvibe_pkg
// Description : Shared types and constants for the RISCVIBE fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscvibe_pkg;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    WAIT  = 3'd1,
    HOLD  = 3'd2,
    FLUSH = 3'd3,
    TRAP  = 3'd4
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Single-outstanding instruction fetch with branch/flush redirect.
//               Define RISCVIBE_MISALIGN_TRAP_EN to trap on misaligned targets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import riscvibe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        misalign_trap,
  output logic [31:0] misalign_addr
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic [31:0]  imem_addr_q, imem_addr_d;
  logic         imem_req_q, imem_req_d;
  logic [31:0]  taken_pc;
  logic         unused_bits;

`ifdef RISCVIBE_MISALIGN_TRAP_EN
  logic         misalign_trap_q, misalign_trap_d;
  logic [31:0]  misalign_addr_q, misalign_addr_d;

  assign taken_pc = {branch_target[31:1], 1'b0};
`else
  assign taken_pc = {branch_target[31:2], 2'b00};
`endif

  assign unused_bits = ^{flush_pc[1:0], branch_target[1:0]};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    imem_req_d  = 1'b0;
    imem_addr_d = imem_addr_q;
`ifdef RISCVIBE_MISALIGN_TRAP_EN
    misalign_trap_d = 1'b0;
    misalign_addr_d = misalign_addr_q;
`endif

    if (flush) begin
      pc_d = {flush_pc[31:2], 2'b00};
      // A response still in flight must be swallowed before refetching;
      // one arriving this very cycle is simply dropped.
      if ((state_q == WAIT || state_q == FLUSH) && !imem_rvalid) begin
        state_d = FLUSH;
      end else begin
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        FETCH: begin
          imem_req_d  = 1'b1;
          imem_addr_d = pc_q;
          state_d     = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            state_d = FETCH;
`ifdef RISCVIBE_MISALIGN_TRAP_EN
            if (branch_taken && branch_target[1]) begin
              state_d         = TRAP;
              misalign_trap_d = 1'b1;
              misalign_addr_d = branch_target;
            end else
`endif
            pc_d = branch_taken ? taken_pc : pc_q + 32'd4;
          end
        end
        FLUSH: begin
          if (imem_rvalid) begin
            state_d = FETCH;
          end
        end
        TRAP:    state_d = TRAP;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      instr_pc_q  <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

`ifdef RISCVIBE_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_trap_q <= 1'b0;
      misalign_addr_q <= 32'h0;
    end else begin
      misalign_trap_q <= misalign_trap_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign misalign_trap = misalign_trap_q;
  assign misalign_addr = misalign_addr_q;
`else
  assign misalign_trap = 1'b0;
  assign misalign_addr = 32'h0;
`endif

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

`default_nettype wire
